// File: rtl/pxs_pkg.sv
// Shared Pixel Stream definitions: stream layout, widths, default VGA timing and colours.
package pxs_pkg;

    localparam int COORD_W   = 10;
    localparam int VGA_STR_W = 23;
    localparam int RGB_STR_W = 26;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int ACTIVE_BIT = 0;
    localparam int VSYNC_BIT  = 1;
    localparam int HSYNC_BIT  = 2;
    localparam int Y_LSB      = 3;
    localparam int Y_MSB      = 12;
    localparam int X_LSB      = 13;
    localparam int X_MSB      = 22;
    localparam int RGB_LSB    = 23;
    localparam int RGB_MSB    = 25;

    // Default 640x480 @ 60 Hz progressive timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hsync;
        logic               vsync;
        logic               active;
    } vga_str_t;

    typedef enum logic [2:0] {
        RGB_BLACK = 3'b000,
        RGB_BLUE  = 3'b001,
        RGB_GREEN = 3'b010,
        RGB_RED   = 3'b100,
        RGB_WHITE = 3'b111
    } rgb_e;

    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/pxs_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap_o flags the increment that returns to 0.
module pxs_mod_counter
    import pxs_pkg::*;
#(
    parameter int MOD = DEF_H_ACTIVE,
    parameter int W   = COORD_W
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q, count_d;

    assign wrap_o  = inc_i && (count_q == LAST);
    assign count_o = count_q;

    // NOTE: count_d gets a default before the conditional so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pxs_vga_stream_gen.sv
// Pixel Stream source: free-running VGA timing with registered sync/coords/active and line/frame strobes.
// Optional frame counter output enabled by defining PXS_FRAME_CNT_EN.
module pxs_vga_stream_gen
    import pxs_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic                 en,
    output logic [VGA_STR_W-1:0] VGAStr_o,
    output logic                 line_start_o,
    output logic                 frame_start_o
`ifdef PXS_FRAME_CNT_EN
    ,
    output logic [7:0]           frame_cnt_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
        $error("pxs_vga_stream_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    // One extra bit so window limits equal to MAX_TOTAL do not truncate.
    localparam int XW = COORD_W + 1;
    localparam logic [XW-1:0] H_ACT_L  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG_L = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END_L = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] V_ACT_L  = XW'(V_ACTIVE);
    localparam logic [XW-1:0] VS_BEG_L = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END_L = XW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    logic [COORD_W-1:0] hcnt, vcnt;
    logic               h_wrap;
    logic               v_wrap_unused;

    pxs_mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_hcnt (
        .clk_i   (px_clk),
        .clear_i (reset),
        .inc_i   (en),
        .count_o (hcnt),
        .wrap_o  (h_wrap)
    );

    pxs_mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_vcnt (
        .clk_i   (px_clk),
        .clear_i (reset),
        .inc_i   (en && h_wrap),
        .count_o (vcnt),
        .wrap_o  (v_wrap_unused)
    );

    vga_str_t str_q, str_d;
    logic     line_start_q, line_start_d;
    logic     frame_start_q, frame_start_d;

    always_comb begin
        logic [XW-1:0] hx, vx;
        hx            = {1'b0, hcnt};
        vx            = {1'b0, vcnt};
        str_d.x       = hcnt;
        str_d.y       = vcnt;
        str_d.active  = (hx < H_ACT_L) && (vx < V_ACT_L);
        str_d.hsync   = sync_level((hx >= HS_BEG_L) && (hx < HS_END_L), HS_ON);
        str_d.vsync   = sync_level((vx >= VS_BEG_L) && (vx < VS_END_L), VS_ON);
        line_start_d  = (hcnt == '0);
        frame_start_d = (hcnt == '0) && (vcnt == '0);
    end

    // Strobes drop to 0 while stalled so a held line/frame start never pulses twice.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            str_q         <= '{x: '0, y: '0, hsync: ~HS_ON, vsync: ~VS_ON, active: 1'b0};
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (en) begin
            str_q         <= str_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign VGAStr_o      = str_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef PXS_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Advances on the same edge that loads frame_start_o high.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (en && frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pxs_vga_stream_gen.sv
// Directed bench for pxs_vga_stream_gen: default-timing vector table plus a small-timing instance
// that covers frame wrap, vsync, stalls and (with PXS_FRAME_CNT_EN) the frame counter.
module tb_pxs_vga_stream_gen;
    import pxs_pkg::*;

    logic        px_clk = 1'b0;
    logic        rst    = 1'b1;
    logic        en     = 1'b0;
    logic        s_rst  = 1'b1;
    logic        s_en   = 1'b0;
    logic [22:0] d_str, s_str;
    logic        d_ls, d_fs, s_ls, s_fs;
`ifdef PXS_FRAME_CNT_EN
    logic [7:0]  d_fc_unused, s_fc;
`endif

    always #5 px_clk = ~px_clk;

    pxs_vga_stream_gen u_dut (
        .px_clk        (px_clk),
        .reset         (rst),
        .en            (en),
        .VGAStr_o      (d_str),
        .line_start_o  (d_ls),
        .frame_start_o (d_fs)
`ifdef PXS_FRAME_CNT_EN
        ,
        .frame_cnt_o   (d_fc_unused)
`endif
    );

    // Tiny 16x11 raster with active-high syncs: hsync x=10..12, vsync y=7..8.
    pxs_vga_stream_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1), .VS_POL(1)
    ) u_small (
        .px_clk        (px_clk),
        .reset         (s_rst),
        .en            (s_en),
        .VGAStr_o      (s_str),
        .line_start_o  (s_ls),
        .frame_start_o (s_fs)
`ifdef PXS_FRAME_CNT_EN
        ,
        .frame_cnt_o   (s_fc)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic en;
        int   n;
        int   x;
        int   y;
        logic act;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, int n, int x, int y,
                                logic a, logic hs, logic vs, logic ls, logic fs);
        vec_t v;
        v.rst = r; v.en = e; v.n = n; v.x = x; v.y = y;
        v.act = a; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
        return v;
    endfunction

    function automatic logic [24:0] pack_exp(int x, int y, logic hs, logic vs, logic a,
                                             logic ls, logic fs);
        logic [9:0] xs, ys;
        xs = 10'(x);
        ys = 10'(y);
        return {xs, ys, hs, vs, a, ls, fs};
    endfunction

    // Independent raster model for the small instance: idx-th pixel since reset release.
    function automatic logic [24:0] small_exp(int idx);
        int x, y;
        x = idx % 16;
        y = (idx / 16) % 11;
        return pack_exp(x, y, (x >= 10 && x < 13), (y >= 7 && y < 9), (x < 8 && y < 6),
                        (x == 0), (x == 0 && y == 0));
    endfunction

    vec_t vt[$];

    initial begin
        int hs_low, hs_min, hs_max, vs_cnt, fs_cnt, k;
        logic [24:0] exp_s;
        logic [7:0]  exp_fc;

        // Default 800x525 timing, active-low syncs; expected X advances one per enabled edge.
        vt.push_back(mk(1, 0,   2,   0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 1,   1,   0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1,   0, 0, 1, 1, 1, 1, 1));
        vt.push_back(mk(0, 1,   1,   1, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,  99, 100, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0,   5, 100, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1, 101, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1, 538, 639, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1, 640, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,  15, 655, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1, 656, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 1,  95, 751, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 1,   1, 752, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,  47, 799, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1,   0, 1, 1, 1, 1, 1, 0));
        vt.push_back(mk(0, 0,   3,   0, 1, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1,   1, 1, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 1, 399, 400, 1, 1, 1, 1, 0, 0));
        vt.push_back(mk(1, 1,   1,   0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1,   1,   0, 0, 1, 1, 1, 1, 1));
        vt.push_back(mk(0, 1,   1,   1, 0, 1, 1, 1, 0, 0));

        #1;
        foreach (vt[i]) begin
            rst = vt[i].rst;
            en  = vt[i].en;
            for (int c = 0; c < vt[i].n; c++) step();
            check($sformatf("vec%0d", i), {7'd0, d_str, d_ls, d_fs},
                  {7'd0, pack_exp(vt[i].x, vt[i].y, vt[i].hs, vt[i].vs, vt[i].act,
                                  vt[i].ls, vt[i].fs)});
        end

        // One full line from X=1: hsync low for exactly X=656..751.
        hs_low = 0; hs_min = 1023; hs_max = -1;
        for (int c = 0; c < 800; c++) begin
            step();
            if (d_str[2] == 1'b0) begin
                hs_low++;
                if (int'(d_str[22:13]) < hs_min) hs_min = int'(d_str[22:13]);
                if (int'(d_str[22:13]) > hs_max) hs_max = int'(d_str[22:13]);
            end
        end
        check("hs_low_cycles", hs_low, 96);
        check("hs_first_x", hs_min, 656);
        check("hs_last_x", hs_max, 751);

        // Small raster: three uninterrupted frames checked pixel by pixel.
        s_rst = 1'b1; s_en = 1'b1;
        step();
        check("small_reset", {7'd0, s_str, s_ls, s_fs}, 32'd0);
        s_rst = 1'b0;
        k = 0; vs_cnt = 0; fs_cnt = 0; exp_fc = 8'd0;
        for (int c = 0; c < 3 * 176; c++) begin
            step();
            exp_s = small_exp(k);
            k++;
            if (exp_s[0]) exp_fc++;
            check("small_run", {7'd0, s_str, s_ls, s_fs}, {7'd0, exp_s});
            if (c < 176 && s_str[1]) vs_cnt++;
            if (s_fs) fs_cnt++;
`ifdef PXS_FRAME_CNT_EN
            if (exp_s[0]) check("frame_cnt_at_fs", s_fc, exp_fc);
`endif
        end
        check("small_vs_cycles", vs_cnt, 32);
        check("small_fs_per_3frames", fs_cnt, 3);

        // Random stalls: outputs hold, strobes forced low, no coordinate skipped or repeated.
        for (int c = 0; c < 400; c++) begin
            s_en = ($urandom_range(0, 3) != 0);
            step();
            if (s_en) begin
                exp_s = small_exp(k);
                k++;
                if (exp_s[0]) exp_fc++;
            end else begin
                exp_s = {exp_s[24:2], 2'b00};
            end
            check("small_stall", {7'd0, s_str, s_ls, s_fs}, {7'd0, exp_s});
`ifdef PXS_FRAME_CNT_EN
            check("frame_cnt_stall", s_fc, exp_fc);
`endif
        end

        // Mid-frame reset: active-high syncs return to their inactive level 0.
        s_rst = 1'b1; s_en = 1'b1;
        step();
        check("small_midreset", {7'd0, s_str, s_ls, s_fs}, 32'd0);
`ifdef PXS_FRAME_CNT_EN
        check("frame_cnt_reset", s_fc, 32'd0);
`endif
        s_rst = 1'b0;
        step();
        check("small_restart", {7'd0, s_str, s_ls, s_fs}, {7'd0, small_exp(0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pxs_vga_stream_gen.md
Name: pxs_vga_stream_gen

Overview:
- Source end of the Pixel Stream pipeline. Produces the 23-bit VGA stream (sync, coordinates, active video; no RGB) that downstream Pxs stages colour and forward.
- Free-running horizontal and vertical timing counters generate 640x480 progressive timing by default. All outputs are registered on px_clk.
- Also emits line-start and frame-start strobes for stages that need per-line or per-frame bookkeeping.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of HSync (0 = active-low)
- VS_POL, 0, asserted level of VSync (0 = active-low)

Ports:
- px_clk  in  1  pixel clock, the only clock
- reset  in  1  synchronous reset, active-high
- en  in  1  count enable; when low, all state holds
- VGAStr_o  out  23  stream: [0] ActiveVideo, [1] VSync, [2] HSync, [12:3] YCoord, [22:13] XCoord
- line_start_o  out  1  one-cycle strobe, aligned with XCoord==0
- frame_start_o  out  1  one-cycle strobe, aligned with XCoord==0 && YCoord==0

Behaviour:
- Clocking and reset: one clock (px_clk). Reset is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; an elaboration-time check fails otherwise.
- Counters: hcnt and vcnt, each 10 bits, unsigned.
- Counting, per px_clk with en=1:
  - hcnt increments; when hcnt==H_TOTAL-1, hcnt wraps to 0 and vcnt advances.
  - vcnt wraps to 0 when vcnt==V_TOTAL-1 and hcnt wraps in the same cycle.
- Output register, loaded in the same cycle from the pre-increment counter values (1-cycle latency, counter to output):
  - XCoord = hcnt; YCoord = vcnt. These are raw counter values and cover blanking, so the range is 0..799 / 0..524.
  - ActiveVideo = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - HSync asserted (HS_POL) for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751; ~HS_POL otherwise.
  - VSync asserted (VS_POL) for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491; VSync is line-based and does not depend on hcnt.
  - line_start_o = (hcnt==0); frame_start_o = (hcnt==0 && vcnt==0).
- en=0: counters and all output registers hold. Strobes are forced to 0 so that no pulse repeats across a stall.
- Reset values:
  - hcnt=0, vcnt=0.
  - VGAStr_o: XCoord=0, YCoord=0, ActiveVideo=0, HSync=~HS_POL, VSync=~VS_POL.
  - line_start_o=0, frame_start_o=0.
- First edge after reset deasserts with en=1: outputs show (0,0), ActiveVideo=1, line_start_o=1, frame_start_o=1.
- Reset mid-frame: on the next edge, counters and outputs return to their reset values. No partial-line flush.
- Reset and en both high: reset wins.
- No state machine beyond the two counters. The sync and active windows are pure compares, registered.

Optional Feature:
- Macro: PXS_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt_o [7:0], reset to 0.
  - Increments (mod 256) on each cycle in which the registered frame_start_o is loaded as 1, so it is updated in the same edge as the strobe.
  - Holds when en=0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pxs_pkg:
  - stream field bit positions (ACTIVE=0, VSYNC=1, HSYNC=2, Y=12:3, X=22:13, RGB=25:23);
  - VGA_STR_W=23, RGB_STR_W=26, COORD_W=10;
  - default 640x480 timing constants;
  - colour constants (black, blue, green, red, white).
- Sub-module pxs_mod_counter: 10-bit modulo counter with inputs inc/clear, parameter MOD, outputs count and wrap. Instantiated twice: horizontal with inc=en, vertical with inc=en && h_wrap.

Test Plan:
- Reset then en=1 → first output XCoord=0, YCoord=0, ActiveVideo=1, HSync=1, VSync=1, frame_start_o=1; on cycle 800, line_start_o=1 and YCoord=1.
- Run one line → ActiveVideo falls at XCoord=640; HSync low for exactly 96 cycles, XCoord 656..751; XCoord wraps 799→0.
- Run a full frame (420000 cycles) → VSync low for YCoord 490..491 (1600 cycles); YCoord wraps 524→0 together with frame_start_o=1; exactly one frame_start_o per frame.
- en low for 5 cycles at XCoord=100 → VGAStr_o frozen, strobes 0; resumes at XCoord=101 with no skipped or duplicated coordinate.
- reset asserted at YCoord=300, XCoord=400 → next output XCoord=0, YCoord=0, ActiveVideo=0, syncs inactive; the frame then restarts cleanly.
- With PXS_FRAME_CNT_EN: 3 full frames → frame_cnt_o reads 1, 2, 3 at each frame_start_o; reset returns it to 0.
